// File: rtl/comb_pkg.sv
// Shared constants, state encoding and small helpers for the combination generator.
// Hit counts and hit indices share one packing: layer L occupies bits [3L+2:3L].
package comb_pkg;

    localparam int NLAYER           = 5;
    localparam int HIT_IDX_W        = 3;
    localparam int NHITS_W          = NLAYER * HIT_IDX_W;
    localparam int CNT_W            = 16;
    localparam int MIN_LAYERS       = 4;
    localparam int MAX_COMB_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_EE_OUT = 2'd2
    } state_e;

    // Number of layers carrying at least one hit.
    function automatic int populated_layers(input logic [NHITS_W-1:0] nhits);
        int n;
        n = 0;
        for (int l = 0; l < NLAYER; l++) begin
            if (nhits[l*HIT_IDX_W +: HIT_IDX_W] != '0) begin
                n++;
            end
        end
        return n;
    endfunction

    // One bit per layer, set when that layer has a nonzero count.
    function automatic logic [NLAYER-1:0] hitmap_of(input logic [NHITS_W-1:0] nhits);
        logic [NLAYER-1:0] m;
        m = '0;
        for (int l = 0; l < NLAYER; l++) begin
            m[l] = (nhits[l*HIT_IDX_W +: HIT_IDX_W] != '0);
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/comb_odometer.sv
// Mixed-radix hit-index counter: layer 0 turns fastest, empty layers stay at 0
// and pass the carry straight through.
module comb_odometer
    import comb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NHITS_W-1:0] counts_i,
    input  logic               advance_i,
    input  logic               clear_i,
    output logic [NHITS_W-1:0] idx_o,
    output logic               last_o
);

    // A layer is "at top" when it holds its final index (or has no hits at all).
    logic [NLAYER-1:0] at_top;

    genvar gi;
    generate
        for (gi = 0; gi < NLAYER; gi++) begin : g_layer
            logic [HIT_IDX_W-1:0] cnt;
            logic [HIT_IDX_W-1:0] idx_q;
            logic [HIT_IDX_W-1:0] idx_d;
            logic                 carry_in;

            assign cnt         = counts_i[gi*HIT_IDX_W +: HIT_IDX_W];
            assign at_top[gi]  = (cnt == '0) || (idx_q == cnt - 1'b1);

            if (gi == 0) begin : g_first
                assign carry_in = advance_i;
            end else begin : g_rest
                assign carry_in = advance_i && (&at_top[gi-1:0]);
            end

            always_comb begin
                idx_d = idx_q;
                if (clear_i) begin
                    idx_d = '0;
                end else if (carry_in && cnt != '0) begin
                    idx_d = at_top[gi] ? '0 : idx_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_d;
                end
            end

            assign idx_o[gi*HIT_IDX_W +: HIT_IDX_W] = idx_q;
        end
    endgenerate

    assign last_o = &at_top;

endmodule

// File: rtl/comb_gen_fsm.sv
// Pops roads from a FWFT FIFO and expands each into its hit combinations, one
// word per unstalled cycle; end-event markers pass through as a single word.
module comb_gen_fsm
    import comb_pkg::*;
#(
    parameter int ROAD_W   = 21,
    parameter int MAX_COMB = MAX_COMB_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               road_empty,
    input  logic [ROAD_W-1:0]  road_id,
    input  logic [NHITS_W-1:0] road_nhits,
    input  logic               road_ee,
    output logic               road_re,
    input  logic               fifo_comb_hfull,
    output logic               fifo_comb_we,
    output logic [ROAD_W-1:0]  comb_road_id,
    output logic [NHITS_W-1:0] comb_hit_idx,
    output logic [NLAYER-1:0]  comb_hitmap,
    output logic               comb_ee,
    output logic               comb_valid,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   trunc_cnt
);

    localparam logic [CNT_W-1:0] MAX_COMB_C = MAX_COMB[CNT_W-1:0];

    state_e             state_q, state_d;
    logic [ROAD_W-1:0]  road_id_q, road_id_d;
    logic [NHITS_W-1:0] nhits_q, nhits_d;
    logic [CNT_W-1:0]   comb_cnt_q, comb_cnt_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   trunc_q, trunc_d;

    logic               pop;
    logic               write;
    logic               odo_clear;
    logic               odo_advance;
    logic               odo_last;
    logic [NHITS_W-1:0] odo_idx;

    // Reset gates the strobes directly so nothing is popped while held in reset.
    assign pop         = (state_q == ST_IDLE) && !road_empty && !fifo_comb_hfull && reset;
    assign write       = (state_q != ST_IDLE) && !fifo_comb_hfull && reset;
    assign odo_advance = write && (state_q == ST_EMIT);

    comb_odometer u_odometer (
        .clk_i     (clock),
        .rst_ni    (reset),
        .counts_i  (nhits_q),
        .advance_i (odo_advance),
        .clear_i   (odo_clear),
        .idx_o     (odo_idx),
        .last_o    (odo_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            road_id_q  <= '0;
            nhits_q    <= '0;
            comb_cnt_q <= '0;
            drop_q     <= '0;
            trunc_q    <= '0;
        end else begin
            state_q    <= state_d;
            road_id_q  <= road_id_d;
            nhits_q    <= nhits_d;
            comb_cnt_q <= comb_cnt_d;
            drop_q     <= drop_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        road_id_d  = road_id_q;
        nhits_d    = nhits_q;
        comb_cnt_d = comb_cnt_q;
        drop_d     = drop_q;
        trunc_d    = trunc_q;
        odo_clear  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    road_id_d = road_id;
                    nhits_d   = road_nhits;
                    if (road_ee) begin
                        state_d = ST_EE_OUT;
                    end else if (populated_layers(road_nhits) >= MIN_LAYERS) begin
                        state_d    = ST_EMIT;
                        odo_clear  = 1'b1;
                        comb_cnt_d = '0;
                    end else begin
                        drop_d = sat_inc(drop_q);
                    end
                end
            end
            ST_EMIT: begin
                if (write) begin
                    comb_cnt_d = comb_cnt_q + 1'b1;
                    // Finishing the road naturally wins over the cap, so an
                    // exact-cap road is not a truncation.
                    if (odo_last) begin
                        state_d = ST_IDLE;
                    end else if (comb_cnt_q + 1'b1 == MAX_COMB_C) begin
                        trunc_d = sat_inc(trunc_q);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EE_OUT: begin
                if (write) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        road_re      = pop;
        fifo_comb_we = write;
        comb_road_id = '0;
        comb_hit_idx = '0;
        comb_hitmap  = '0;
        comb_ee      = 1'b0;
        comb_valid   = 1'b0;
        unique case (state_q)
            ST_EMIT: begin
                comb_road_id = road_id_q;
                comb_hit_idx = odo_idx;
                comb_hitmap  = hitmap_of(nhits_q);
                comb_valid   = 1'b1;
            end
            ST_EE_OUT: begin
                comb_ee    = 1'b1;
                comb_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign drop_cnt  = drop_q;
    assign trunc_cnt = trunc_q;

endmodule

// File: tb/tb_comb_gen_fsm.sv
// Directed bench: a queue-backed FWFT road FIFO feeds the generator and every
// written word is captured and compared against a mixed-radix expectation.
module tb_comb_gen_fsm;

    logic        clock = 1'b0;
    logic        reset;
    logic        road_empty;
    logic [20:0] road_id;
    logic [14:0] road_nhits;
    logic        road_ee;
    logic        road_re;
    logic        fifo_comb_hfull;
    logic        fifo_comb_we;
    logic [20:0] comb_road_id;
    logic [14:0] comb_hit_idx;
    logic [4:0]  comb_hitmap;
    logic        comb_ee;
    logic        comb_valid;
    logic [15:0] drop_cnt;
    logic [15:0] trunc_cnt;

    always #5 clock = ~clock;

    comb_gen_fsm #(.ROAD_W(21), .MAX_COMB(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .road_empty      (road_empty),
        .road_id         (road_id),
        .road_nhits      (road_nhits),
        .road_ee         (road_ee),
        .road_re         (road_re),
        .fifo_comb_hfull (fifo_comb_hfull),
        .fifo_comb_we    (fifo_comb_we),
        .comb_road_id    (comb_road_id),
        .comb_hit_idx    (comb_hit_idx),
        .comb_hitmap     (comb_hitmap),
        .comb_ee         (comb_ee),
        .comb_valid      (comb_valid),
        .drop_cnt        (drop_cnt),
        .trunc_cnt       (trunc_cnt)
    );

    typedef struct {
        logic [20:0] id;
        logic [14:0] nh;
        logic        ee;
    } road_t;

    typedef struct {
        logic [42:0] word;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [14:0] nh;
        logic        ee;
        int          nwr;
        logic [4:0]  map;
        int          ddrop;
        int          dtrunc;
    } vec_t;

    road_t roadq[$];
    wr_t   capq[$];
    int    popq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rst_v = 1'b0;
    bit hfull_v = 1'b0;
    bit toggle_v = 1'b0;
    int wr_seen;

    function automatic logic [14:0] pk(int c0, int c1, int c2, int c3, int c4);
        return {3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    function automatic logic [42:0] pack_w(logic ee, logic valid, logic [4:0] map,
                                           logic [14:0] idx, logic [20:0] id);
        return {ee, valid, map, idx, id};
    endfunction

    // k-th combination as a mixed-radix number, layer 0 least significant.
    function automatic logic [14:0] exp_idx(logic [14:0] nh, int k);
        logic [14:0] r;
        int rad;
        r = '0;
        rad = 1;
        for (int l = 0; l < 5; l++) begin
            int c;
            c = int'(nh[3*l +: 3]);
            if (c != 0) begin
                r[3*l +: 3] = 3'((k / rad) % c);
                rad = rad * c;
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_road(logic [20:0] id, logic [14:0] nh, logic ee);
        road_t r;
        r.id = id;
        r.nh = nh;
        r.ee = ee;
        roadq.push_back(r);
    endtask

    task automatic step();
        wr_t w;
        @(negedge clock);
        if (toggle_v) hfull_v = ((cyc / 3) % 2) == 1;
        reset           = rst_v;
        fifo_comb_hfull = hfull_v;
        road_empty      = (roadq.size() == 0);
        if (roadq.size() != 0) begin
            road_id    = roadq[0].id;
            road_nhits = roadq[0].nh;
            road_ee    = roadq[0].ee;
        end else begin
            road_id    = '0;
            road_nhits = '0;
            road_ee    = 1'b0;
        end
        #1;
        if (fifo_comb_we) begin
            chk("we_while_hfull", 64'(fifo_comb_hfull), 64'd0);
            w.word = pack_w(comb_ee, comb_valid, comb_hitmap, comb_hit_idx, comb_road_id);
            w.cyc  = cyc;
            capq.push_back(w);
            wr_seen++;
        end
        if (road_re) begin
            chk("re_we_excl", 64'(fifo_comb_we), 64'd0);
            popq.push_back(cyc);
            if (roadq.size() != 0) void'(roadq.pop_front());
        end
        cyc++;
    endtask

    task automatic run_until_idle(string nm, int bound);
        int quiet;
        quiet = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (fifo_comb_we || road_re || roadq.size() != 0) quiet = 0;
            else quiet++;
            if (quiet >= 8) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: still busy after %0d cycles, want idle", nm, bound);
    endtask

    task automatic check_words(string nm, logic [20:0] id, logic [14:0] nh, logic ee,
                               logic [4:0] map, int nwr, int base);
        logic [42:0] exp;
        for (int k = 0; k < nwr && base + k < capq.size(); k++) begin
            if (ee) exp = pack_w(1'b1, 1'b1, 5'b0, 15'b0, 21'b0);
            else    exp = pack_w(1'b0, 1'b1, map, exp_idx(nh, k), id);
            chk($sformatf("%s_w%0d", nm, k), 64'(capq[base + k].word), 64'(exp));
        end
    endtask

    vec_t vt[10];

    initial begin
        logic [15:0] d0, t0;
        vt[0] = '{pk(2,1,1,1,1), 1'b0, 2,  5'b11111, 0, 0};
        vt[1] = '{pk(3,0,2,1,1), 1'b0, 6,  5'b11101, 0, 0};
        vt[2] = '{pk(1,0,0,1,1), 1'b0, 0,  5'b00000, 1, 0};
        vt[3] = '{pk(7,7,7,1,1), 1'b0, 64, 5'b11111, 0, 1};
        vt[4] = '{pk(2,2,2,1,1), 1'b0, 8,  5'b11111, 0, 0};
        vt[5] = '{pk(4,4,4,1,0), 1'b0, 64, 5'b01111, 0, 0};
        vt[6] = '{pk(0,1,1,1,1), 1'b0, 1,  5'b11110, 0, 0};
        vt[7] = '{pk(7,0,0,0,0), 1'b1, 1,  5'b00000, 0, 0};
        vt[8] = '{pk(0,0,7,7,7), 1'b0, 0,  5'b00000, 1, 0};
        vt[9] = '{pk(1,1,1,1,1), 1'b0, 1,  5'b11111, 0, 0};

        reset = 1'b0;
        road_empty = 1'b1;
        road_id = '0;
        road_nhits = '0;
        road_ee = 1'b0;
        fifo_comb_hfull = 1'b0;

        // Held in reset with a road waiting: nothing may be popped or written.
        push_road(21'h1ABCD, pk(2,1,1,1,1), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_re", 64'(road_re), 64'd0);
            chk("rst_we", 64'(fifo_comb_we), 64'd0);
        end
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_trunc", 64'(trunc_cnt), 64'd0);

        rst_v = 1'b1;
        run_until_idle("first", 100);
        chk("first_pops", 64'(popq.size()), 64'd1);
        chk("first_nwr", 64'(capq.size()), 64'd2);
        if (popq.size() == 1 && capq.size() == 2) begin
            chk("first_latency", 64'(capq[0].cyc), 64'(popq[0] + 1));
            chk("first_back2back", 64'(capq[1].cyc), 64'(capq[0].cyc + 1));
        end
        check_words("first", 21'h1ABCD, pk(2,1,1,1,1), 1'b0, 5'b11111, 2, 0);
        capq.delete();
        popq.delete();

        // Two roads queued: exactly one IDLE (pop) cycle between them.
        push_road(21'h00A01, pk(2,1,1,1,1), 1'b0);
        push_road(21'h00A02, pk(2,1,1,1,1), 1'b0);
        run_until_idle("gap", 100);
        chk("gap_nwr", 64'(capq.size()), 64'd4);
        if (popq.size() == 2 && capq.size() == 4) begin
            chk("gap_pop2", 64'(popq[1]), 64'(capq[1].cyc + 1));
            chk("gap_first2", 64'(capq[2].cyc), 64'(popq[1] + 1));
        end
        check_words("gap_a", 21'h00A01, pk(2,1,1,1,1), 1'b0, 5'b11111, 2, 0);
        check_words("gap_b", 21'h00A02, pk(2,1,1,1,1), 1'b0, 5'b11111, 2, 2);
        capq.delete();
        popq.delete();

        for (int v = 0; v < 10; v++) begin
            d0 = drop_cnt;
            t0 = trunc_cnt;
            push_road(21'h10000 + 21'(v), vt[v].nh, vt[v].ee);
            run_until_idle($sformatf("vec%0d", v), 300);
            chk($sformatf("vec%0d_nwr", v), 64'(capq.size()), 64'(vt[v].nwr));
            check_words($sformatf("vec%0d", v), 21'h10000 + 21'(v), vt[v].nh, vt[v].ee,
                        vt[v].map, vt[v].nwr, 0);
            chk($sformatf("vec%0d_drop", v), 64'(drop_cnt), 64'(d0 + 16'(vt[v].ddrop)));
            chk($sformatf("vec%0d_trunc", v), 64'(trunc_cnt), 64'(t0 + 16'(vt[v].dtrunc)));
            $display("vec%0d nhits=%h ee=%0b writes=%0d drop=%0d trunc=%0d",
                     v, vt[v].nh, vt[v].ee, capq.size(), drop_cnt, trunc_cnt);
            capq.delete();
            popq.delete();
        end

        // Back-pressure toggling every 3 cycles must not lose or repeat a tuple.
        toggle_v = 1'b1;
        push_road(21'h0BEEF, pk(2,2,2,1,1), 1'b0);
        run_until_idle("stall", 300);
        toggle_v = 1'b0;
        hfull_v = 1'b0;
        chk("stall_nwr", 64'(capq.size()), 64'd8);
        check_words("stall", 21'h0BEEF, pk(2,2,2,1,1), 1'b0, 5'b11111, 8, 0);
        capq.delete();
        popq.delete();

        // End-event word after a road, then reset in the middle of a long road.
        push_road(21'h0C0DE, pk(2,1,1,1,1), 1'b0);
        push_road(21'h1FFFF, pk(3,3,3,3,3), 1'b1);
        run_until_idle("ee", 100);
        chk("ee_nwr", 64'(capq.size()), 64'd3);
        check_words("ee_road", 21'h0C0DE, pk(2,1,1,1,1), 1'b0, 5'b11111, 2, 0);
        check_words("ee_word", 21'h0, 15'h0, 1'b1, 5'b0, 1, 2);
        capq.delete();
        popq.delete();

        push_road(21'h0D00D, pk(7,7,7,1,1), 1'b0);
        for (int i = 0; i < 50 && capq.size() < 5; i++) step();
        chk("mid_started", 64'(capq.size() >= 5), 64'd1);
        chk("mid_drop_pre", 64'(drop_cnt), 64'd2);
        capq.delete();
        rst_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_we", 64'(fifo_comb_we), 64'd0);
            chk("midrst_re", 64'(road_re), 64'd0);
        end
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        chk("midrst_trunc", 64'(trunc_cnt), 64'd0);
        rst_v = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("abandoned_nwr", 64'(capq.size()), 64'd0);
        capq.delete();
        popq.delete();

        push_road(21'h0E0E0, pk(2,1,1,1,1), 1'b0);
        run_until_idle("resume", 100);
        chk("resume_nwr", 64'(capq.size()), 64'd2);
        check_words("resume", 21'h0E0E0, pk(2,1,1,1,1), 1'b0, 5'b11111, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
